bbpd_vote: RTL and testbench

//  Alexander (bang-bang) phase detector with windowed majority vote; sits directly

---
 rtl/cdr_pkg.sv | 17 +
 rtl/bbpd_vote_if.sv | 12 +
 rtl/bbpd_vote_core.sv | 39 +++
 rtl/bbpd_vote.sv | 83 ++++++++
 tb/tb_bbpd_vote.sv | 125 ++++++++++++
 5 files changed

// File: rtl/cdr_pkg.sv
// Types and helpers shared by the CDR front end: phase detector, loop filter, NCO.
package cdr_pkg;

  typedef enum logic [1:0] {
    VOTE_NONE  = 2'd0,
    VOTE_EARLY = 2'd1,
    VOTE_LATE  = 2'd2
  } vote_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bbpd_vote_if.sv
// Symbol sample inputs and loop-filter decision outputs of the bang-bang detector.
interface bbpd_vote_if;
  logic sym_valid;
  logic d_smp;
  logic e_smp;
  logic en;
  logic R;
  logic V;

  modport master (output sym_valid, d_smp, e_smp, input en, R, V);
  modport slave  (input sym_valid, d_smp, e_smp, output en, R, V);
endinterface

// File: rtl/bbpd_vote_core.sv
// Alexander classifier: remembers the previous data sample and labels each symbol.
module bbpd_vote_core
  import cdr_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  sym_valid_i,
  input  logic  d_smp_i,
  input  logic  e_smp_i,
  output vote_t vote_o
);

  logic d_prev_q, d_prev_d;
  logic dvld_q, dvld_d;

  always_comb begin
    d_prev_d = d_prev_q;
    dvld_d   = dvld_q;
    vote_o   = VOTE_NONE;
    if (sym_valid_i) begin
      d_prev_d = d_smp_i;
      dvld_d   = 1'b1;
      // With a transition, the edge sample equals exactly one of the two data samples.
      if (dvld_q && (d_prev_q != d_smp_i))
        vote_o = (e_smp_i == d_smp_i) ? VOTE_LATE : VOTE_EARLY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_prev_q <= 1'b0;
      dvld_q   <= 1'b0;
    end else begin
      d_prev_q <= d_prev_d;
      dvld_q   <= dvld_d;
    end
  end

endmodule

// File: rtl/bbpd_vote.sv
// Windowed majority vote over Alexander PD symbols; one R/V decision per WIN symbols.
module bbpd_vote
  import cdr_pkg::*;
#(
  parameter int WIN    = 16,
  parameter int THRESH = 2
) (
  input logic        clk,
  input logic        rst,
  bbpd_vote_if.slave bus
);

  localparam int CW = clog2(WIN);
  localparam int SW = CW + 2;
  localparam logic [CW-1:0]        LAST     = CW'(WIN - 1);
  localparam logic signed [SW-1:0] ONE      = SW'(1);
  localparam logic signed [SW-1:0] MONE     = -SW'(1);
  localparam logic signed [SW-1:0] THRESH_S = SW'(THRESH);

  vote_t vote;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [SW-1:0] sum_q, sum_d, sum_nx;
  logic en_q, en_d, r_q, r_d, v_q, v_d;

  bbpd_vote_core u_core (
    .clk         (clk),
    .rst         (rst),
    .sym_valid_i (bus.sym_valid),
    .d_smp_i     (bus.d_smp),
    .e_smp_i     (bus.e_smp),
    .vote_o      (vote)
  );

  always_comb begin
    unique case (vote)
      VOTE_LATE:  sum_nx = sum_q + ONE;
      VOTE_EARLY: sum_nx = sum_q + MONE;
      default:    sum_nx = sum_q;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    sum_d = sum_q;
    en_d  = 1'b0;
    r_d   = 1'b0;
    v_d   = 1'b0;
    if (bus.sym_valid) begin
      if (cnt_q == LAST) begin
        // Decision uses the sum including the closing symbol; next window starts from 0.
        cnt_d = '0;
        sum_d = '0;
        en_d  = 1'b1;
        r_d   = (sum_nx > THRESH_S);
        v_d   = (sum_nx < -THRESH_S);
      end else begin
        cnt_d = cnt_q + 1'b1;
        sum_d = sum_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sum_q <= '0;
      en_q  <= 1'b0;
      r_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      en_q  <= en_d;
      r_q   <= r_d;
      v_q   <= v_d;
    end
  end

  assign bus.en = en_q;
  assign bus.R  = r_q;
  assign bus.V  = v_q;

endmodule

// File: tb/tb_bbpd_vote.sv
// Directed bench for bbpd_vote (WIN=16, THRESH=2); expected {en,R,V} hand-derived per cycle.
module tb_bbpd_vote;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  bbpd_vote_if bus ();

  bbpd_vote #(.WIN(16), .THRESH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic v, input logic d, input logic e);
    @(negedge clk);
    bus.sym_valid = v;
    bus.d_smp     = d;
    bus.e_smp     = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {bus.en, bus.R, bus.V};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed{en,R,V}=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic d, v;
    int   sent, ncyc;
    bus.sym_valid = 1'b0;
    bus.d_smp     = 1'b0;
    bus.e_smp     = 1'b0;

    // reset with random samples
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      chk($sformatf("reset[%0d]", i), 3'b000);
    end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("post_reset", 3'b000);

    // all late: first symbol NONE, 15 LATE -> +15 -> R
    for (int i = 0; i < 16; i++) begin
      d = 1'(i % 2);
      cyc(1'b1, d, d);
      chk($sformatf("late[%0d]", i), (i == 15) ? 3'b110 : 3'b000);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("late_pulse_end", 3'b000);

    // all early, two abutting windows: -16 each -> V
    for (int i = 0; i < 32; i++) begin
      d = 1'(i % 2);
      cyc(1'b1, d, ~d);
      chk($sformatf("early[%0d]", i), (i == 15 || i == 31) ? 3'b101 : 3'b000);
    end

    // dead zone: 9 late + 7 early = +2 -> en only
    for (int i = 0; i < 16; i++) begin
      d = 1'(i % 2);
      cyc(1'b1, d, (i < 9) ? d : ~d);
      chk($sformatf("dz2[%0d]", i), (i == 15) ? 3'b100 : 3'b000);
    end

    // 9 late + 6 early + 1 none = +3 -> R
    for (int i = 0; i < 16; i++) begin
      d = (i == 15) ? 1'b0 : 1'(i % 2);
      cyc(1'b1, d, (i < 9) ? d : ~d);
      chk($sformatf("dz3[%0d]", i), (i == 15) ? 3'b110 : 3'b000);
    end

    // constant d=1 with random gaps: one LATE at the 0->1 step, rest NONE -> +1
    sent = 0;
    ncyc = 0;
    while (sent < 16) begin
      v = ($urandom_range(1, 0) == 1) || (ncyc >= 40);
      if (v) begin
        cyc(1'b1, 1'b1, 1'b1);
        sent++;
      end else begin
        cyc(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
      ncyc++;
      chk($sformatf("notrans[%0d]", ncyc), (v && sent == 16) ? 3'b100 : 3'b000);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("notrans_pulse_end", 3'b000);

    // mid-window reset after 10 late symbols
    for (int i = 0; i < 10; i++) begin
      d = 1'(i % 2);
      cyc(1'b1, d, d);
      chk($sformatf("pre_rst[%0d]", i), 3'b000);
    end
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("mid_rst", 3'b000);
    rst = 1'b0;
    // first post-reset symbol NONE, then 15 EARLY -> -15 -> V
    for (int i = 0; i < 16; i++) begin
      d = 1'(i % 2);
      cyc(1'b1, d, ~d);
      chk($sformatf("post_rst[%0d]", i), (i == 15) ? 3'b101 : 3'b000);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("final_idle", 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
